// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus tick-sampled debounce for the board slide switches.
// Each bit must differ from sw_out for STABLE_TICKS consecutive ticks before it is accepted.
module sw_debounce #(
  parameter int WIDTH        = 18,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 16,
  parameter int CNT_W        = 16,
  parameter int STB_W        = 5,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] sw_change,
  output logic             any_change
);

  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [STB_W-1:0] CTR_LAST = STB_W'(STABLE_TICKS - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] update;
  logic [CNT_W-1:0] pre;
  logic [STB_W-1:0] ctr [WIDTH];
  logic             tick;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= RESET_VAL;
      sync2 <= RESET_VAL;
    end else begin
      sync1 <= sw_in;
      sync2 <= sync1;
    end
  end

  // With TICK_DIV = 1 the prescaler sits at 0 and tick is permanently high.
  assign tick = (pre == PRE_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + CNT_W'(1);
    end
  end

  always_comb begin
    update = '0;
    for (int i = 0; i < WIDTH; i++) begin
      update[i] = tick && (sync2[i] != sw_out[i]) && (ctr[i] == CTR_LAST);
    end
  end

  // A tick that sees the input back at the output level restarts qualification.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        ctr[i] <= '0;
      end
    end else if (tick) begin
      for (int i = 0; i < WIDTH; i++) begin
        if ((sync2[i] == sw_out[i]) || update[i]) begin
          ctr[i] <= '0;
        end else begin
          ctr[i] <= ctr[i] + STB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_out     <= RESET_VAL;
      sw_change  <= '0;
      any_change <= 1'b0;
    end else begin
      sw_out     <= (sw_out & ~update) | (sync2 & update);
      sw_change  <= update;
      any_change <= |update;
    end
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce with TICK_DIV=4, STABLE_TICKS=3; a second
// instance with all-ones reset level checks for spurious pulses on reset release.
module tb_sw_debounce;

  localparam int W = 18;

  typedef struct {
    logic [W-1:0] out;
    logic [W-1:0] chg;
    int           lo;
    int           hi;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] sw_in = '0;
  logic [W-1:0] sw_out;
  logic [W-1:0] sw_change;
  logic         any_change;
  logic [W-1:0] sw_in_hi = '1;
  logic [W-1:0] sw_out_hi;
  logic [W-1:0] sw_change_hi;
  logic         any_change_hi;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t got;

  sw_debounce #(
    .WIDTH(W), .TICK_DIV(4), .STABLE_TICKS(3), .CNT_W(4), .STB_W(2),
    .RESET_VAL(18'h00000)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sw_in(sw_in),
    .sw_out(sw_out), .sw_change(sw_change), .any_change(any_change)
  );

  sw_debounce #(
    .WIDTH(W), .TICK_DIV(4), .STABLE_TICKS(3), .CNT_W(4), .STB_W(2),
    .RESET_VAL(18'h3FFFF)
  ) dut_hi (
    .clk(clk), .reset_n(reset_n), .sw_in(sw_in_hi),
    .sw_out(sw_out_hi), .sw_change(sw_change_hi), .any_change(any_change_hi)
  );

  always #5 clk = ~clk;

  // cyc = posedges since reset release, so tick edges fall on multiples of 4.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    checks++;
    if (any_change !== |sw_change) begin
      errors++;
      $display("[TB] FAIL any_change_or cyc=%0d: any_change=%b, required %b", cyc, any_change, |sw_change);
    end
    if (reset_n) begin
      checks++;
      if (any_change_hi !== 1'b0 || sw_change_hi !== '0) begin
        errors++;
        $display("[TB] FAIL alt_pulse cyc=%0d: sw_change=%h any_change=%b, required 0", cyc, sw_change_hi, any_change_hi);
      end
      if (any_change) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_pulse cyc=%0d: sw_change=%h sw_out=%h, required no pulse", cyc, sw_change, sw_out);
        end else begin
          got = sb.pop_front();
          if (sw_change !== got.chg || sw_out !== got.out || cyc < got.lo || cyc > got.hi) begin
            errors++;
            $display("[TB] FAIL scoreboard cyc=%0d: sw_out=%h sw_change=%h, required sw_out=%h sw_change=%h in cycles %0d..%0d",
                     cyc, sw_out, sw_change, got.out, got.chg, got.lo, got.hi);
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic [W-1:0] v, input bit expect_pulse,
                               input logic [W-1:0] exp_out, input logic [W-1:0] exp_chg,
                               input int lo_off, input int hi_off);
    exp_t n;
    sw_in = v;
    if (expect_pulse) begin
      n.out = exp_out;
      n.chg = exp_chg;
      n.lo  = cyc + lo_off;
      n.hi  = cyc + hi_off;
      sb.push_back(n);
    end
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] exp_out,
                             input logic [W-1:0] exp_chg, input logic exp_any);
    checks++;
    if (sw_out !== exp_out || sw_change !== exp_chg || any_change !== exp_any) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d: sw_out=%h sw_change=%h any=%b, required sw_out=%h sw_change=%h any=%b",
               name, cyc, sw_out, sw_change, any_change, exp_out, exp_chg, exp_any);
    end
  endtask

  task automatic checkAlt(input string name);
    checks++;
    if (sw_out_hi !== 18'h3FFFF || sw_change_hi !== '0) begin
      errors++;
      $display("[TB] FAIL %s: sw_out=%h sw_change=%h, required sw_out=3ffff sw_change=0", name, sw_out_hi, sw_change_hi);
    end
  endtask

  task automatic waitAfterTick();
    do @(negedge clk); while (cyc % 4 != 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset_state", 18'h0, 18'h0, 1'b0);
    checkAlt("alt_reset_state");
    reset_n = 1'b1;
    repeat (100) @(negedge clk);
    checkOutput("idle_zero", 18'h0, 18'h0, 1'b0);
    checkAlt("alt_idle");

    $display("[TB] single-bit step on bit 0");
    waitAfterTick();
    applyStimulus(18'h00001, 1'b1, 18'h00001, 18'h00001, 12, 12);
    repeat (11) @(negedge clk);
    checkOutput("step0_not_early", 18'h0, 18'h0, 1'b0);
    @(negedge clk);
    checkOutput("step0_pulse", 18'h00001, 18'h00001, 1'b1);
    @(negedge clk);
    checkOutput("step0_held", 18'h00001, 18'h0, 1'b0);
    applyStimulus(18'h00000, 1'b1, 18'h00000, 18'h00001, 11, 14);
    repeat (16) @(negedge clk);
    checkOutput("release0", 18'h0, 18'h0, 1'b0);

    $display("[TB] bouncing bit 5");
    for (int k = 0; k < 5; k++) begin
      applyStimulus(18'h00020, 1'b0, 18'h0, 18'h0, 0, 0);
      repeat (8) @(negedge clk);
      applyStimulus(18'h00000, 1'b0, 18'h0, 18'h0, 0, 0);
      repeat (8) @(negedge clk);
    end
    checkOutput("bounce5", 18'h0, 18'h0, 1'b0);

    $display("[TB] all bits together");
    applyStimulus(18'h3FFFF, 1'b1, 18'h3FFFF, 18'h3FFFF, 11, 14);
    repeat (16) @(negedge clk);
    checkOutput("all_rise", 18'h3FFFF, 18'h0, 1'b0);
    applyStimulus(18'h00000, 1'b1, 18'h00000, 18'h3FFFF, 11, 14);
    repeat (16) @(negedge clk);
    checkOutput("all_fall", 18'h0, 18'h0, 1'b0);

    $display("[TB] reset during qualification of bit 17");
    waitAfterTick();
    applyStimulus(18'h20000, 1'b0, 18'h0, 18'h0, 0, 0);
    repeat (8) @(negedge clk);
    checkOutput("b17_pre_reset", 18'h0, 18'h0, 1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("b17_in_reset", 18'h0, 18'h0, 1'b0);
    checkAlt("alt_in_reset");
    applyStimulus(18'h20000, 1'b1, 18'h20000, 18'h20000, 12, 12);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (11) @(negedge clk);
    checkOutput("b17_not_early", 18'h0, 18'h0, 1'b0);
    @(negedge clk);
    checkOutput("b17_pulse", 18'h20000, 18'h20000, 1'b1);
    repeat (4) @(negedge clk);
    checkOutput("b17_held", 18'h20000, 18'h0, 1'b0);
    checkAlt("alt_after_reset");

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL missing_pulses: %0d expected pulses outstanding, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
